shared_adder_arbiter: RTL and testbench

Shares one N-bit ripple-carry adder (RCAG) among NREQ requesters. Round-robin selection, registered operands, and a programmable settle window give the long carry chain a multi-cycle path. Sits between requesting datapath units and the single adder instance; returns sum, carry-out and requester ID over a valid/ready response port.

---
 rtl/shared_adder_arbiter_pkg.sv | 18 +
 rtl/shared_adder_arbiter_if.sv | 38 +++
 rtl/rcag.sv | 28 ++
 rtl/shared_adder_arbiter_rr_arbiter.sv | 40 ++++
 rtl/shared_adder_arbiter.sv | 139 +++++++++++++
 tb/tb_shared_adder_arbiter.sv | 256 +++++++++++++++++++++++++
 6 files changed

// File: rtl/shared_adder_arbiter_pkg.sv
// shared_adder_arbiter_pkg
//   Shared definitions for the shared-adder arbiter: FSM state encoding and
//   the requester-ID width derivation used by the top, the arbiter and the
//   bus interface.
package shared_adder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    // ID width: at least one bit even when there is a single requester.
    function automatic int idw_of(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/shared_adder_arbiter_if.sv
// shared_adder_arbiter_if
//   Request/response bundle between the requesting datapath units (master)
//   and the shared adder arbiter (slave).
//   req_valid/req_a/req_b : per-requester request, requester i at [i*N +: N]
//   req_ready             : one-hot accept from the arbiter
//   rsp_valid/rsp_ready   : response handshake
//   rsp_sum/rsp_cout/rsp_id : result and the index of the requester served
//   busy                  : arbiter is computing or holding a response
interface shared_adder_arbiter_if
    import shared_adder_arbiter_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = idw_of(NREQ)
) ();

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );

endinterface

// File: rtl/rcag.sv
// rcag
//   N-bit ripple-carry adder, no carry-in.
//   a, b : operands
//   sum  : low N bits of a + b
//   cout : carry out of bit N-1
module rcag #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic carry;

    // Carry is walked bit by bit so the chain stays a true ripple structure.
    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// shared_adder_arbiter_rr_arbiter
//   Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index for this round
//   en        : when low, no grant is issued
//   grant     : one-hot grant
//   grant_idx : encoded index of the granted requester
//   grant_any : a grant was issued
module shared_adder_arbiter_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    int idx;

    // Scan ptr, ptr+1, ... modulo NREQ; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (en && !grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
//   Shares one ripple-carry adder among NREQ requesters. A round-robin grant
//   latches one requester's operands, the adder is given SETTLE cycles to
//   propagate, and the result is returned over a valid/ready response.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
module shared_adder_arbiter
    import shared_adder_arbiter_pkg::*;
#(
    parameter int N      = 32,
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shared_adder_arbiter_if.slave  bus
);

    localparam int IDW = idw_of(NREQ);
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] op_id;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;

    logic           rsp_valid;
    logic [N-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [IDW-1:0] rsp_id;
    logic           busy;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            arb_en;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] id);
        if (int'(id) >= NREQ - 1) return '0;
        return id + IDW'(1);
    endfunction

    // Grants only in IDLE; gating with rst_n keeps req_ready low during reset
    // even though state already reads IDLE.
    assign arb_en = (state == IDLE) && rst_n;

    shared_adder_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The adder only ever sees the latched operands, so its inputs are frozen
    // for the whole settle window (multicycle path op_* -> rsp_*).
    rcag #(
        .N (N)
    ) u_add (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operand capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (arb_en && grant_any) begin
            op_a <= bus.req_a[int'(grant_idx)*N +: N];
            op_b <= bus.req_b[int'(grant_idx)*N +: N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            op_id     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_id <= grant_idx;
                        cnt   <= CW'(SETTLE - 1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ptr_after(op_id);
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_sum   = rsp_sum;
    assign bus.rsp_cout  = rsp_cout;
    assign bus.rsp_id    = rsp_id;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter
//   Directed bench for shared_adder_arbiter with a transaction-level model
//   compared against the DUT every cycle, plus literal spot checks.
module tb_shared_adder_arbiter;
    import shared_adder_arbiter_pkg::*;

    localparam int N      = 32;
    localparam int NREQ   = 4;
    localparam int SETTLE = 2;
    localparam int IDW    = idw_of(NREQ);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_adder_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    shared_adder_arbiter #(.N(N), .NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // A transaction is: pick a requester round-robin, wait SETTLE cycles,
    // present A+B until consumed, then move priority past the served id.
    bit             m_pend, m_rv;
    int             m_wait, m_pid, m_id, m_ptr, m_grant;
    logic [N:0]     m_full;
    logic [N-1:0]   m_sum;
    logic           m_cout;
    logic [NREQ-1:0] m_ready;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always_comb begin
        m_grant = (rst_n && !m_pend && !m_rv) ? pick(bus.req_valid, m_ptr) : -1;
        m_ready = (m_grant >= 0) ? (NREQ'(1) << m_grant) : '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 0; m_rv <= 0; m_wait <= 0; m_pid <= 0; m_id <= 0; m_ptr <= 0;
            m_full <= '0; m_sum <= '0; m_cout <= 1'b0;
        end else if (m_rv) begin
            if (bus.rsp_ready) begin
                m_rv  <= 0;
                m_ptr <= (m_id + 1) % NREQ;
            end
        end else if (m_pend) begin
            if (m_wait == 1) begin
                m_rv   <= 1;
                m_pend <= 0;
                m_sum  <= m_full[N-1:0];
                m_cout <= m_full[N];
                m_id   <= m_pid;
            end else begin
                m_wait <= m_wait - 1;
            end
        end else if (m_grant >= 0) begin
            m_pend <= 1;
            m_wait <= SETTLE;
            m_pid  <= m_grant;
            m_full <= {1'b0, bus.req_a[m_grant*N +: N]} + {1'b0, bus.req_b[m_grant*N +: N]};
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc = 0;
    int acc_id[$];
    int acc_cyc[$];

    always @(negedge clk) begin
        bit found;
        cyc++;
        check("req_ready", 64'(bus.req_ready), 64'(m_ready));
        check("req_ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
        check("busy", 64'(bus.busy), 64'(m_pend || m_rv));
        check("rsp_sum", 64'(bus.rsp_sum), 64'(m_sum));
        check("rsp_cout", 64'(bus.rsp_cout), 64'(m_cout));
        check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_ready[k] && bus.req_valid[k]) begin
                found = 1;
                acc_id.push_back(k);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_valid[i]     = v;
        bus.req_a[i*N +: N]  = a;
        bus.req_b[i*N +: N]  = b;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            tick(1);
            lat++;
        end
        check("rsp_seen", 64'(bus.rsp_valid), 64'd1);
    endtask

    // Single transaction from an idle arbiter with rsp_ready=1.
    task automatic txn(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] exp_sum, input logic exp_cout);
        int lat;
        set_req(i, 1'b1, a, b);
        tick(1);
        set_req(i, 1'b0, '0, '0);
        wait_rsp(lat);
        check("latency", 64'(lat), 64'(SETTLE));
        check("lit_sum", 64'(bus.rsp_sum), 64'(exp_sum));
        check("lit_cout", 64'(bus.rsp_cout), 64'(exp_cout));
        check("lit_id", 64'(bus.rsp_id), 64'(i));
        tick(1);
    endtask

    initial begin
        int lat;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        tick(2);
        bus.req_valid = '1;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_rsp_sum", 64'(bus.rsp_sum), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        bus.req_valid = '0;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Basic adds and overflow cases.
        txn(2, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0);
        txn(1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        txn(0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        txn(3, 32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221, 1'b0);

        // All four valid continuously; last served was 3 so rotation starts at 0.
        acc_id.delete();
        acc_cyc.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'h1111_1111 * (i + 1), 32'h10 * i);
        tick(20);
        bus.req_valid = '0;
        check("rr_accepts", 64'(acc_id.size()), 64'd5);
        if (acc_id.size() >= 5) begin
            check("rr_id0", 64'(acc_id[0]), 64'd0);
            check("rr_id1", 64'(acc_id[1]), 64'd1);
            check("rr_id2", 64'(acc_id[2]), 64'd2);
            check("rr_id3", 64'(acc_id[3]), 64'd3);
            check("rr_id4", 64'(acc_id[4]), 64'd0);
            for (int k = 0; k < 4; k++)
                check("rr_spacing", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'd4);
        end
        tick(2);

        // Backpressure: priority now starts at 1, so 2 wins over 0.
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'd7, 32'd8);
        set_req(2, 1'b1, 32'd100, 32'd23);
        tick(1);
        set_req(2, 1'b0, '0, '0);
        wait_rsp(lat);
        check("bp_id", 64'(bus.rsp_id), 64'd2);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_hold_sum", 64'(bus.rsp_sum), 64'd123);
            check("bp_hold_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        tick(1);
        check("bp_next_grant", 64'(bus.req_ready), 64'b0001);
        tick(1);
        set_req(0, 1'b0, '0, '0);
        wait_rsp(lat);
        check("bp_next_id", 64'(bus.rsp_id), 64'd0);
        check("bp_next_sum", 64'(bus.rsp_sum), 64'd15);
        tick(1);

        // Fairness with gaps: serve 3, then only 1 and 3 valid.
        txn(3, 32'd1, 32'd2, 32'd3, 1'b0);
        set_req(1, 1'b1, 32'd10, 32'd20);
        set_req(3, 1'b1, 32'd30, 32'd40);
        #1;
        check("gap_grant1", 64'(bus.req_ready), 64'b0010);
        tick(1);
        set_req(1, 1'b0, '0, '0);
        wait_rsp(lat);
        check("gap_id1", 64'(bus.rsp_id), 64'd1);
        tick(1);
        check("gap_grant3", 64'(bus.req_ready), 64'b1000);
        tick(1);
        set_req(3, 1'b0, '0, '0);
        wait_rsp(lat);
        check("gap_id3", 64'(bus.rsp_id), 64'd3);
        check("gap_sum3", 64'(bus.rsp_sum), 64'd70);
        tick(1);

        // Reset one cycle into CALC: no response, priority back to 0.
        set_req(2, 1'b1, 32'd4, 32'd4);
        tick(1);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        set_req(0, 1'b1, 32'd9, 32'd1);
        tick(2);
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 64'(bus.req_ready), 64'b0001);
        tick(1);
        bus.req_valid = '0;
        wait_rsp(lat);
        check("post_rst_id", 64'(bus.rsp_id), 64'd0);
        check("post_rst_sum", 64'(bus.rsp_sum), 64'd10);
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
